// File: rtl/conv_pkg.sv
// Shared constants and window-layout helper for the convolution datapath.
// The MAC stage uses win_off() so both sides agree on the flattened window order.
package conv_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_K        = 3;
  localparam int DEF_LINE_LEN = 8;

  // Bit offset of window element (r,c); r=0 oldest row, c=0 leftmost column.
  function automatic int win_off(input int r, input int c, input int k, input int data_w);
    return (r * k + c) * data_w;
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle of the sliding-window generator.
interface conv_window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [K*K*DATA_W-1:0] out_window;
  logic                  out_eol;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_window, out_eol
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_window, out_eol
  );

endinterface

// File: rtl/conv_window_buffer_line_mem.sv
// One image line of pixel storage: asynchronous read, synchronous write.
module line_mem #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 8,
  parameter int ADDR_W   = $clog2(LINE_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINE_LEN];

  // NOTE: storage has no reset; a reset would block RAM inference, and the
  // row gate upstream guarantees stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding KxK window generator: K-1 line memories feed a KxK shift-register
// array; a registered output stage carries one window per accepted pixel.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int K        = DEF_K
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  conv_window_buffer_if.slave  bus
);

  localparam int COL_W = $clog2(LINE_LEN);
  localparam int ROW_W = $clog2(K);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FULL      = ROW_W'(K - 1);

  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic                  accept;
  logic                  win_gate;

  logic [DATA_W-1:0]     rd_data [K-1];
  logic [DATA_W-1:0]     wr_data [K-1];
  logic [DATA_W-1:0]     new_col [K];
  logic [DATA_W-1:0]     win_q   [K][K];
  logic [DATA_W-1:0]     win_d   [K][K];
  logic [K*K*DATA_W-1:0] win_flat;

  assign bus.in_ready = !clear && (!bus.out_valid || bus.out_ready);
  // rst_n gates the accept so a pixel presented during reset is never stored.
  assign accept   = rst_n && bus.in_valid && bus.in_ready;
  assign win_gate = (row_cnt == ROW_FULL) && (col_cnt >= COL_FIRST_WIN);

  // Vertical rotate: each line takes the next-younger line's pixel at this column.
  for (genvar j = 0; j < K - 1; j++) begin : g_line
    if (j < K - 2) begin : g_mid
      assign wr_data[j] = rd_data[j+1];
    end else begin : g_top
      assign wr_data[j] = bus.in_data;
    end

    line_mem #(
      .DATA_W   (DATA_W),
      .LINE_LEN (LINE_LEN),
      .ADDR_W   (COL_W)
    ) u_line_mem (
      .clk   (clk),
      .we    (accept),
      .waddr (col_cnt),
      .wdata (wr_data[j]),
      .raddr (col_cnt),
      .rdata (rd_data[j])
    );
  end

  // NOTE: combinational logic uses blocking '=' and every output gets a
  // default first, so no latch can be inferred.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K - 1; r++) new_col[r] = rd_data[r];
    new_col[K-1] = bus.in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = new_col[r];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[win_off(r, c, K, DATA_W) +: DATA_W] = win_d[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (accept) win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (row_cnt != ROW_FULL) row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_eol    <= 1'b0;
      bus.out_window <= '0;
    end else if (clear) begin
      bus.out_valid <= 1'b0;
    end else if (accept && win_gate) begin
      bus.out_valid  <= 1'b1;
      bus.out_eol    <= (col_cnt == COL_LAST);
      bus.out_window <= win_flat;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: fill, line wrap, backpressure,
// clear, reset mid-frame and clear/valid collision, with pixel = row*8+col.
module tb_conv_window_buffer;

  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 8;
  localparam int K        = 3;
  localparam int W        = K * K * DATA_W;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int vectors     = 0;
  int miscompares = 0;
  int wins;
  int eols;

  conv_window_buffer_if #(.DATA_W(DATA_W), .K(K)) bus ();

  conv_window_buffer #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .K        (K)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Window ending at raster index p: element (r,c) is pixel p-(K-1-r)*LINE_LEN-(K-1-c).
  function automatic logic [W-1:0] exp_win(input int p, input int off);
    logic [W-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DATA_W +: DATA_W] = DATA_W'(off + p - (K-1-r)*LINE_LEN - (K-1-c));
    return w;
  endfunction

  // Present pixel p until accepted, then check the registered output.
  task automatic push(input int p, input int off);
    bit acc;
    bit vld;
    int guard;
    acc   = 1'b0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(off + p);
    while (!acc && guard < 20) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("accept p%0d", p), W'(acc), W'(1));
    vld = ((p / LINE_LEN) >= K-1) && ((p % LINE_LEN) >= K-1);
    check($sformatf("out_valid p%0d", p), W'(bus.out_valid), W'(vld));
    if (vld) begin
      check($sformatf("out_window p%0d", p), bus.out_window, exp_win(p, off));
      check($sformatf("out_eol p%0d", p), W'(bus.out_eol), W'((p % LINE_LEN) == LINE_LEN-1));
    end
    if (bus.out_valid === 1'b1) wins++;
    if (bus.out_valid === 1'b1 && bus.out_eol === 1'b1) eols++;
  endtask

  task automatic fill(input int off);
    wins = 0;
    eols = 0;
    for (int p = 0; p < 4*LINE_LEN; p++) push(p, off);
    check("window count", W'(wins), W'(12));
    check("eol count", W'(eols), W'(2));
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset out_eol", W'(bus.out_eol), W'(0));
    check("reset out_window", bus.out_window, W'(0));
    check("reset in_ready", W'(bus.in_ready), W'(1));

    // Full 4-row frame: first window at 18, wrap suppresses 24/25, eol at 23/31.
    fill(0);

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear drops out_valid", W'(bus.out_valid), W'(0));

    // Backpressure with window (...,18) pending.
    for (int p = 0; p <= 18; p++) push(p, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd19;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp in_ready %0d", i), W'(bus.in_ready), W'(0));
      check($sformatf("bp out_valid %0d", i), W'(bus.out_valid), W'(1));
      check($sformatf("bp out_window %0d", i), bus.out_window, exp_win(18, 0));
      @(posedge clk);
    end
    #1;
    check("bp held window", bus.out_window, exp_win(18, 0));
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp next valid", W'(bus.out_valid), W'(1));
    check("bp next window", bus.out_window, exp_win(19, 0));
    push(20, 0);

    // Clear after pixel 20, then refeed the frame with +100 values.
    clear = 1'b1;
    #1;
    check("clear in_ready", W'(bus.in_ready), W'(0));
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear mid-frame out_valid", W'(bus.out_valid), W'(0));
    for (int p = 0; p <= 18; p++) push(p, 100);

    // Reset for one cycle with a pixel presented.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd119;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    check("mid reset out_valid", W'(bus.out_valid), W'(0));
    check("mid reset out_eol", W'(bus.out_eol), W'(0));
    check("mid reset out_window", bus.out_window, W'(0));

    // clear and in_valid together: no accept; the pixel is retried next cycle.
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd50;
    #1;
    check("collide in_ready", W'(bus.in_ready), W'(0));
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("collide out_valid", W'(bus.out_valid), W'(0));
    fill(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
